rr_master_req_ctrl: RTL

- Master-side request controller. It produces the per-master `sforN` / `req_statN` signals that each slave's ack arbiter samples, and it consumes that arbiter's `ackN` response.
- Commands (target slave number) are queued in a small FIFO and issued one at a time.
- Each issued request walks through SEND, then W_ACK (wait for acknowledge), with a timeout and a bounded retry.
- Completion and error are reported to the master core as single-cycle pulses.

---
 rtl/rr_master_req_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rr_master_req_ctrl.sv
// Master-side request controller.
// Commands naming a target slave are queued in a small FIFO and issued one at
// a time. Each request walks SEND -> W_ACK, waiting for the selected slave's
// acknowledge. If no ack arrives in time, the request backs off in HOLD and is
// re-issued. Once the retries run out, the command is dropped with an err pulse.
module rr_master_req_ctrl #(
   parameter int TIMEOUT    = 16,
   parameter int MAX_RETRY  = 3,
   parameter int BACKOFF    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic       cmd_slave,
   output logic       cmd_ready,
   input  logic       ack0,
   input  logic       ack1,
   output logic       sfor,
   output logic [1:0] req_stat,
   output logic       done,
   output logic       err,
   output logic       busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [PTR_W:0] DEPTH_CNT    = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [7:0]     TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0]     BACKOFF_LAST = 8'(BACKOFF - 1);
   localparam logic [3:0]     RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      W_ACK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t           state;
   logic             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [7:0]       timer;
   logic [3:0]       retry;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic ack_sel;

   assign full      = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   // The only dequeue point is the IDLE -> SEND launch of a new request.
   assign pop       = (state == IDLE) && !empty;
   // Only the slave this request targets may complete it.
   assign ack_sel   = sfor ? ack1 : ack0;
   assign req_stat  = state;
   assign busy      = (state != IDLE) || !empty;

   // Command storage; contents need no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cmd_slave;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Request sequencing with registered sfor/done/err; the timer is shared by W_ACK and HOLD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sfor  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         timer <= '0;
         retry <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  sfor  <= fifo_mem[rd_ptr];
                  retry <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               timer <= '0;
               state <= W_ACK;
            end
            W_ACK: begin
               if (ack_sel) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (timer == TIMEOUT_LAST) begin
                  if (retry < RETRY_LIMIT) begin
                     retry <= retry + 1'b1;
                     timer <= '0;
                     state <= HOLD;
                  end else begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            HOLD: begin
               if (timer == BACKOFF_LAST) begin
                  timer <= '0;
                  state <= SEND;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
